peripheral_timer_bus: RTL and testbench
=======================================

Name: peripheral_timer_bus

Overview:
- Memory-mapped peripheral responder on the MEM-stage data bus, alongside DataMemory.
- The MEM stage drives Address, Write_data, MemRead and MemWrite. This block decodes its own address window and answers reads combinationally in the same cycle. It commits writes on the clock edge.
- Contents: programmable reload timer with interrupt, free-running systick counter, and an 8-bit LED register. The MEM-stage read mux uses the hit output to select this block's Read_data over DataMemory.

Parameters:
- BASE_ADDR, 32'h40000000, window base. The window is 32 bytes and word-aligned; decode uses Address[31:5].
- LED_W, 8, LED register width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- Address  in  32  byte address from the MEM stage (ALU result).
- Write_data  in  32  store data (databus B).
- MemRead  in  1  load strobe (control bit 11 upstream).
- MemWrite  in  1  store strobe (control bit 12 upstream).
- Read_data  out  32  load data, combinational.
- hit  out  1  Address lies in the window; combinational, independent of strobes.
- irq  out  1  timer interrupt request, level = TCON[2].
- led  out  LED_W  LED register contents.

Behaviour:
- Register map (offset = Address[4:2]):
  - 0: TH, reload value, R/W.
  - 1: TL, counter, R/W.
  - 2: TCON[2:0], R/W. Bit 0 = enable, bit 1 = interrupt enable, bit 2 = interrupt status.
  - 3: LED, R/W, low LED_W bits.
  - 4: SYSTICK, read-only.
  - 5–7: reserved; read 0, writes ignored.
- Address[1:0] is ignored. Accesses are always full words.
- Read_data:
  - Equals the register selected by offset when MemRead=1 and hit=1.
  - Otherwise 32'h0.
  - TCON reads zero-extended from 3 bits; LED reads zero-extended from LED_W bits.
- Writes: occur on the rising edge when MemWrite=1 and hit=1. MemRead and MemWrite both high: the read is combinational, the write commits at the edge.
- Reset (reset=0 at a rising edge): TH, TL, TCON, LED and SYSTICK all clear to 0, so irq=0 and led=0. Reset overrides any write or count in the same cycle. Read_data stays purely combinational from the cleared registers.
- SYSTICK: increments by 1 every non-reset cycle. Wraps 32'hFFFFFFFF -> 0. Writes to it are ignored.
- Timer, evaluated each non-reset edge while TCON[0]=1:
  - If TL==32'hFFFFFFFF: TL<=TH, and if TCON[1]=1 then TCON[2]<=1.
  - Else TL<=TL+1.
  - While TCON[0]=0, TL holds.
- TCON[2] is sticky. It is cleared only by a bus write with Write_data[2]=0, or by reset. A bus write with bit 2 = 1 sets it.
- Simultaneous events, same edge:
  - Bus write to TL vs. count/reload: the bus write wins.
  - Bus write to TCON vs. overflow setting TCON[2]: the bus write value wins.
  - Bus write to TH during overflow: TL reloads with the old TH; the new TH takes effect at the next overflow.
- irq is combinational from the TCON[2] register, with no extra latency. The interrupt is visible the cycle after the overflow edge.
- Timing: one-cycle write latency; zero-cycle read latency.

Decomposition:
- Shared package (peripheral_pkg):
  - Offset constants: OFF_TH=3'd0, OFF_TL=3'd1, OFF_TCON=3'd2, OFF_LED=3'd3, OFF_SYSTICK=3'd4.
  - TCON bit indices: TCON_EN=0, TCON_IE=1, TCON_IS=2.
  - BASE_ADDR default.
- One natural sub-module: reload_timer. It holds TH, TL and TCON, the count/reload logic and irq, and takes write-enable, select and data from the decoder.
- The top level holds the address decode, LED, SYSTICK and the read mux.

Test Plan:
- Reset: hold reset=0 for 2 cycles with MemWrite=1 to 0x40000000 -> TH, TL, TCON, LED and SYSTICK all read 0; irq=0; led=0.
- Decode:
  - Address 0x3FFFFFFC -> hit=0, Read_data=0.
  - Address 0x40000010 with MemRead=1 -> hit=1, Read_data = SYSTICK value.
  - Address 0x40000014 -> hit=1, Read_data=0.
  - Address 0x40000020 -> hit=0.
- Reload and interrupt:
  - Setup: write TH=32'hFFFFFFF0, TL=32'hFFFFFFFE, TCON=3'b011.
  - The edge after TL reaches 32'hFFFFFFFF sets TL=32'hFFFFFFF0, and irq rises 1 cycle later.
  - Subsequent counting continues from 32'hFFFFFFF1.
- Interrupt clear: with irq=1, write TCON=3'b011 -> irq=0 next cycle and the timer keeps running. Write TCON=3'b001 through the next overflow -> TL reloads, irq stays 0.
- Collision:
  - Write TL=32'h5 on the same edge TL would wrap -> TL=5 and TCON[2] unchanged.
  - Write TCON=3'b011 on the overflow edge -> TCON[2]=0.
- LED and SYSTICK:
  - Write 32'h1A5 to 0x4000000C -> led=8'hA5; reading it returns 32'h000000A5.
  - Write 32'h12345678 to SYSTICK -> ignored.
  - Two reads N cycles apart differ by exactly N.

Source files
------------

// File: rtl/peripheral_pkg.sv
// Shared definitions for the memory-mapped timer peripheral.
// Holds the register offset map (Address[4:2]), TCON bit positions and the
// default window base address used by peripheral_timer_bus.
package peripheral_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h4000_0000;

  // Word offsets inside the 32-byte window.
  localparam logic [2:0] OFF_TH      = 3'd0;
  localparam logic [2:0] OFF_TL      = 3'd1;
  localparam logic [2:0] OFF_TCON    = 3'd2;
  localparam logic [2:0] OFF_LED     = 3'd3;
  localparam logic [2:0] OFF_SYSTICK = 3'd4;

  // TCON bit indices.
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

endpackage

// File: rtl/peripheral_timer_bus_reload_timer.sv
// reload_timer: programmable reload counter with sticky interrupt status.
// Ports:
//   clk, reset    - clock, synchronous active-low reset
//   i_we          - bus write strobe (already qualified by the window hit)
//   i_sel         - register offset being written
//   i_wdata       - bus write data
//   o_th, o_tl    - reload value and counter, for the read mux
//   o_tcon        - {IS, IE, EN}
//   o_irq         - interrupt request, level of TCON[IS]
module reload_timer
  import peripheral_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we,
  input  logic [2:0]  i_sel,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_th,
  output logic [31:0] o_tl,
  output logic [2:0]  o_tcon,
  output logic        o_irq
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;

  logic w_wr_th;
  logic w_wr_tl;
  logic w_wr_tcon;
  logic w_overflow;

  assign w_wr_th    = i_we && (i_sel == OFF_TH);
  assign w_wr_tl    = i_we && (i_sel == OFF_TL);
  assign w_wr_tcon  = i_we && (i_sel == OFF_TCON);
  assign w_overflow = r_tcon[TCON_EN] && (r_tl == 32'hFFFF_FFFF);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; later assignments in this block override
  // earlier ones, which is how bus writes take priority over the timer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
    end else begin
      // A bus write to TL cancels the whole count/reload event, including
      // the interrupt it would have raised.
      if (r_tcon[TCON_EN] && !w_wr_tl) begin
        if (w_overflow) begin
          r_tl <= r_th;  // old TH, even if TH is written on this edge
          if (r_tcon[TCON_IE])
            r_tcon[TCON_IS] <= 1'b1;
        end else begin
          r_tl <= r_tl + 32'd1;
        end
      end

      if (w_wr_th)   r_th   <= i_wdata;
      if (w_wr_tl)   r_tl   <= i_wdata;
      if (w_wr_tcon) r_tcon <= i_wdata[2:0];
    end
  end

  assign o_th   = r_th;
  assign o_tl   = r_tl;
  assign o_tcon = r_tcon;
  assign o_irq  = r_tcon[TCON_IS];

endmodule

// File: rtl/peripheral_timer_bus.sv
// peripheral_timer_bus: MEM-stage bus responder for a 32-byte window holding
// a reload timer, a free-running SYSTICK counter and an LED register.
// Ports:
//   clk, reset   - clock, synchronous active-low reset
//   Address      - byte address from the MEM stage; Address[4:2] selects
//   Write_data   - store data
//   MemRead      - load strobe (gates Read_data)
//   MemWrite     - store strobe (commits on the rising edge)
//   Read_data    - combinational load data, zero when not selected
//   hit          - Address lies in this window, independent of strobes
//   irq          - timer interrupt request
//   led          - LED register contents
module peripheral_timer_bus
  import peripheral_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int          LED_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Address,
  input  logic [31:0]      Write_data,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic [31:0]      Read_data,
  output logic             hit,
  output logic             irq,
  output logic [LED_W-1:0] led
);

  logic [2:0]       w_offset;
  logic             w_we;
  logic [31:0]      w_th;
  logic [31:0]      w_tl;
  logic [2:0]       w_tcon;
  logic             w_unused;

  logic [LED_W-1:0] r_led;
  logic [31:0]      r_systick;

  assign hit      = (Address[31:5] == BASE_ADDR[31:5]);
  assign w_offset = Address[4:2];
  assign w_we     = MemWrite && hit;
  // Byte lanes are not supported; accesses are always full words.
  assign w_unused = &{1'b0, Address[1:0]};

  reload_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_sel   (w_offset),
    .i_wdata (Write_data),
    .o_th    (w_th),
    .o_tl    (w_tl),
    .o_tcon  (w_tcon),
    .o_irq   (irq)
  );

  // SYSTICK ignores bus writes; it only counts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_led     <= '0;
      r_systick <= '0;
    end else begin
      r_systick <= r_systick + 32'd1;
      if (w_we && (w_offset == OFF_LED))
        r_led <= Write_data[LED_W-1:0];
    end
  end

  assign led = r_led;

  // NOTE: Read_data gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    Read_data = '0;
    if (MemRead && hit) begin
      case (w_offset)
        OFF_TH:      Read_data = w_th;
        OFF_TL:      Read_data = w_tl;
        OFF_TCON:    Read_data = {29'd0, w_tcon};
        OFF_LED:     Read_data = {{(32-LED_W){1'b0}}, r_led};
        OFF_SYSTICK: Read_data = r_systick;
        default:     Read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_timer_bus.sv
// Directed testbench for peripheral_timer_bus.
module tb_peripheral_timer_bus;

  localparam logic [31:0] A_TH      = 32'h4000_0000;
  localparam logic [31:0] A_TL      = 32'h4000_0004;
  localparam logic [31:0] A_TCON    = 32'h4000_0008;
  localparam logic [31:0] A_LED     = 32'h4000_000C;
  localparam logic [31:0] A_SYSTICK = 32'h4000_0010;
  localparam logic [31:0] A_RSV     = 32'h4000_0014;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] Write_data = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Read_data;
  logic        hit;
  logic        irq;
  logic [7:0]  led;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference tick count: cleared by reset, +1 on every other edge.
  logic [31:0] exp_tick = '0;

  peripheral_timer_bus dut (
    .clk        (clk),
    .reset      (reset),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Read_data  (Read_data),
    .hit        (hit),
    .irq        (irq),
    .led        (led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) exp_tick <= '0;
    else        exp_tick <= exp_tick + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    Address    = addr;
    Write_data = data;
    MemWrite   = 1'b1;
    @(posedge clk);
    #1;
    MemWrite   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    Address = addr;
    MemRead = 1'b1;
    #1;
    data    = Read_data;
    MemRead = 1'b0;
    #1;
  endtask

  logic [31:0] rd;
  logic [31:0] s0;
  logic [31:0] s1;

  initial begin
    // Reset held two edges with a competing write to TH.
    Address    = A_TH;
    Write_data = 32'hDEAD_BEEF;
    MemWrite   = 1'b1;
    tick(2);
    MemWrite   = 1'b0;
    bus_read(A_TH, rd);      check("rst_th", rd, 32'h0);
    bus_read(A_TL, rd);      check("rst_tl", rd, 32'h0);
    bus_read(A_TCON, rd);    check("rst_tcon", rd, 32'h0);
    bus_read(A_LED, rd);     check("rst_led_reg", rd, 32'h0);
    bus_read(A_SYSTICK, rd); check("rst_systick", rd, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_led", {24'd0, led}, 32'h0);

    reset = 1'b1;

    // Decode.
    Address = 32'h3FFF_FFFC; MemRead = 1'b1; #1;
    check("dec_below_hit", {31'd0, hit}, 32'h0);
    check("dec_below_rd", Read_data, 32'h0);
    MemRead = 1'b0;
    tick(3);
    bus_read(A_SYSTICK, rd);
    check("dec_systick_hit", {31'd0, hit}, 32'h1);
    check("dec_systick_val", rd, 32'd3);
    check("dec_systick_model", rd, exp_tick);
    bus_read(A_RSV, rd);
    check("dec_rsv_hit", {31'd0, hit}, 32'h1);
    check("dec_rsv_rd", rd, 32'h0);
    Address = 32'h4000_0020; #1;
    check("dec_above_hit", {31'd0, hit}, 32'h0);
    bus_write(A_RSV, 32'hFFFF_FFFF);
    bus_read(A_RSV, rd);     check("rsv_write_ignored", rd, 32'h0);

    // Reload and interrupt.
    bus_write(A_TH, 32'hFFFF_FFF0);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'h3);
    Address = A_TL; #1;
    check("rd_gated_by_memread", Read_data, 32'h0);
    bus_read(A_TH, rd);      check("th_written", rd, 32'hFFFF_FFF0);
    bus_read(A_TL, rd);      check("tl_start", rd, 32'hFFFF_FFFE);
    tick(1);
    bus_read(A_TL, rd);      check("tl_max", rd, 32'hFFFF_FFFF);
    check("irq_before_ovf", {31'd0, irq}, 32'h0);
    tick(1);
    bus_read(A_TL, rd);      check("tl_reload", rd, 32'hFFFF_FFF0);
    check("irq_after_ovf", {31'd0, irq}, 32'h1);
    bus_read(A_TCON, rd);    check("tcon_is_set", rd, 32'h7);
    tick(1);
    bus_read(A_TL, rd);      check("tl_after_reload", rd, 32'hFFFF_FFF1);
    check("irq_sticky", {31'd0, irq}, 32'h1);

    // Interrupt clear, then overflow with interrupts disabled.
    bus_write(A_TCON, 32'h3);
    check("irq_cleared", {31'd0, irq}, 32'h0);
    bus_read(A_TL, rd);      check("tl_keeps_running", rd, 32'hFFFF_FFF2);
    bus_write(A_TCON, 32'h1);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_read(A_TL, rd);      check("tl_write_wins_count", rd, 32'hFFFF_FFFE);
    tick(2);
    bus_read(A_TL, rd);      check("tl_reload_ie0", rd, 32'hFFFF_FFF0);
    check("irq_ie0", {31'd0, irq}, 32'h0);
    bus_read(A_TCON, rd);    check("tcon_ie0", rd, 32'h1);

    // Collision: TL write on the wrap edge.
    bus_write(A_TCON, 32'h3);
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TL, 32'h5);
    bus_read(A_TL, rd);      check("col_tl_write", rd, 32'h5);
    bus_read(A_TCON, rd);    check("col_tl_tcon", rd, 32'h3);
    check("col_tl_irq", {31'd0, irq}, 32'h0);

    // Collision: TCON write on the overflow edge.
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TCON, 32'h3);
    bus_read(A_TCON, rd);    check("col_tcon", rd, 32'h3);
    bus_read(A_TL, rd);      check("col_tcon_tl", rd, 32'hFFFF_FFF0);
    check("col_tcon_irq", {31'd0, irq}, 32'h0);

    // Collision: TH write on the overflow edge reloads the old TH.
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TH, 32'h0000_0100);
    bus_read(A_TL, rd);      check("col_th_tl", rd, 32'hFFFF_FFF0);
    bus_read(A_TH, rd);      check("col_th_new", rd, 32'h0000_0100);
    check("col_th_irq", {31'd0, irq}, 32'h1);

    // LED and SYSTICK.
    bus_write(A_LED, 32'h0000_01A5);
    check("led_out", {24'd0, led}, 32'hA5);
    bus_read(A_LED, rd);     check("led_read", rd, 32'h0000_00A5);
    bus_read(A_SYSTICK, s0); check("systick_model0", s0, exp_tick);
    bus_write(A_SYSTICK, 32'h1234_5678);
    bus_read(A_SYSTICK, s1); check("systick_write_ignored", s1, s0 + 32'd1);
    tick(7);
    bus_read(A_SYSTICK, rd); check("systick_delta7", rd - s1, 32'd7);
    check("systick_model1", rd, exp_tick);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
